// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back sequencer.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_NOP  = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2,
        WB_SWAP = 2'd3
    } wb_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SWAP1 = 2'd2,
        SWAP2 = 2'd3
    } wb_state_t;

    localparam int WB_CNT_W = 16;

    function automatic logic wb_op_is_write(input wb_op_t op);
        return (op == WB_ALU) || (op == WB_LOAD);
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Request, register-file read/write and counter signals of the write-back sequencer.
interface reg_writeback_if #(
    parameter int PW = 4
);
    import wb_pkg::*;

    logic                req_valid;
    logic                req_ready;
    wb_op_t              req_op;
    logic [PW:0]         req_addr_a;
    logic [PW:0]         req_addr_b;
    logic [7:0]          alu_dat;
    logic [7:0]          mem_dat;
    logic [7:0]          rf_datA;
    logic [7:0]          rf_datB;
    logic                rf_wr_en;
    logic [PW:0]         rf_wr_addr;
    logic [7:0]          rf_dat;
    logic                rf_doSWAP;
    logic [WB_CNT_W-1:0] wb_cnt;

    // Upstream pipeline plus register-file read ports.
    modport master (
        output req_valid, req_op, req_addr_a, req_addr_b, alu_dat, mem_dat,
               rf_datA, rf_datB,
        input  req_ready, rf_wr_en, rf_wr_addr, rf_dat, rf_doSWAP, wb_cnt
    );

    // The write-back sequencer itself.
    modport slave (
        input  req_valid, req_op, req_addr_a, req_addr_b, alu_dat, mem_dat,
               rf_datA, rf_datB,
        output req_ready, rf_wr_en, rf_wr_addr, rf_dat, rf_doSWAP, wb_cnt
    );

endinterface

// File: rtl/reg_writeback_fwd_mux.sv
// Forwards the in-flight register-file write to a read that targets the same
// address, since the register file has not committed it yet.
module wb_fwd_mux #(
    parameter int PW = 4
) (
    input  logic        wr_en_i,
    input  logic [PW:0] wr_addr_i,
    input  logic [7:0]  wr_dat_i,
    input  logic [PW:0] rd_addr_i,
    input  logic [7:0]  rd_dat_i,
    output logic [7:0]  fwd_dat_o
);

    always_comb begin
        fwd_dat_o = rd_dat_i;
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            fwd_dat_o = wr_dat_i;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back sequencer driving the register file's single write port with
// registered ALU/LOAD writes and two-cycle SWAP sequences.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int PW = 4
) (
    input  logic            clk,
    input  logic            reset,
    reg_writeback_if.slave  bus
);

    wb_state_t           state_q;
    logic                rf_wr_en_q;
    logic [PW:0]         rf_wr_addr_q;
    logic [7:0]          rf_dat_q;
    logic                rf_doswap_q;
    logic [WB_CNT_W-1:0] wb_cnt_q;
    logic [WB_CNT_W-1:0] wb_cnt_d;
    logic [PW:0]         swap_addr_a_q;
    logic [7:0]          hold_b_q;

    logic                accept;
    logic [7:0]          wr_dat_d;
    logic [7:0]          fwd_a;
    logic [7:0]          fwd_b;

    assign bus.req_ready = !reset && (state_q != SWAP1);
    assign accept        = bus.req_valid && bus.req_ready;
    assign wr_dat_d      = (bus.req_op == WB_LOAD) ? bus.mem_dat : bus.alu_dat;
    assign wb_cnt_d      = wb_cnt_q + WB_CNT_W'(rf_wr_en_q);

    wb_fwd_mux #(.PW(PW)) u_fwd_a (
        .wr_en_i   (rf_wr_en_q),
        .wr_addr_i (rf_wr_addr_q),
        .wr_dat_i  (rf_dat_q),
        .rd_addr_i (bus.req_addr_a),
        .rd_dat_i  (bus.rf_datA),
        .fwd_dat_o (fwd_a)
    );

    wb_fwd_mux #(.PW(PW)) u_fwd_b (
        .wr_en_i   (rf_wr_en_q),
        .wr_addr_i (rf_wr_addr_q),
        .wr_dat_i  (rf_dat_q),
        .rd_addr_i (bus.req_addr_b),
        .rd_dat_i  (bus.rf_datB),
        .fwd_dat_o (fwd_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: swap_addr_a_q/hold_b_q are only read in SWAP1 after being
            // loaded, so they are deliberately left out of reset.
            state_q      <= IDLE;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_dat_q     <= '0;
            rf_doswap_q  <= 1'b0;
            wb_cnt_q     <= '0;
        end else begin
            wb_cnt_q <= wb_cnt_d;
            if (state_q == SWAP1) begin
                state_q      <= SWAP2;
                rf_wr_en_q   <= 1'b1;
                rf_wr_addr_q <= swap_addr_a_q;
                rf_dat_q     <= hold_b_q;
                rf_doswap_q  <= 1'b1;
            end else if (accept && wb_op_is_write(bus.req_op)) begin
                state_q      <= WRITE;
                rf_wr_en_q   <= 1'b1;
                rf_wr_addr_q <= bus.req_addr_a;
                rf_dat_q     <= wr_dat_d;
                rf_doswap_q  <= 1'b0;
            end else if (accept && (bus.req_op == WB_SWAP)) begin
                // First swap write goes to addr_b; the addr_a write follows in SWAP1.
                state_q       <= SWAP1;
                rf_wr_en_q    <= 1'b1;
                rf_wr_addr_q  <= bus.req_addr_b;
                rf_dat_q      <= fwd_a;
                rf_doswap_q   <= 1'b1;
                swap_addr_a_q <= bus.req_addr_a;
                hold_b_q      <= fwd_b;
            end else begin
                state_q     <= IDLE;
                rf_wr_en_q  <= 1'b0;
                rf_doswap_q <= 1'b0;
            end
        end
    end

    assign bus.rf_wr_en   = rf_wr_en_q;
    assign bus.rf_wr_addr = rf_wr_addr_q;
    assign bus.rf_dat     = rf_dat_q;
    assign bus.rf_doSWAP  = rf_doswap_q;
    assign bus.wb_cnt     = wb_cnt_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a behavioural register file plus an
// architectural register model that predicts every write-port cycle.
module tb_reg_writeback;
    import wb_pkg::*;

    localparam int PW = 4;
    localparam int NREG = 1 << (PW + 1);

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_mis = 0;

    reg_writeback_if #(.PW(PW)) bus ();

    reg_writeback #(.PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT write port, read combinationally.
    logic [7:0] rf_mem [NREG];
    always @(posedge clk) begin
        if (bus.rf_wr_en) rf_mem[bus.rf_wr_addr] <= bus.rf_dat;
    end
    assign bus.rf_datA = rf_mem[bus.req_addr_a];
    assign bus.rf_datB = rf_mem[bus.req_addr_b];

    // Reference model: arch holds register values after every issued write.
    logic [7:0]  arch [NREG];
    logic        m_pend = 1'b0;
    logic [PW:0] m_pend_addr;
    logic [7:0]  m_pend_dat;
    logic        m_en = 1'b0;
    logic [PW:0] m_addr = '0;
    logic [7:0]  m_dat = '0;
    logic        m_swap = 1'b0;
    logic [15:0] m_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input wb_op_t op,
                        input logic [PW:0] a, input logic [PW:0] b,
                        input logic [7:0] ad, input logic [7:0] md);
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] cnt_n;
        @(negedge clk);
        reset          = rst;
        bus.req_valid  = v;
        bus.req_op     = op;
        bus.req_addr_a = a;
        bus.req_addr_b = b;
        bus.alu_dat    = ad;
        bus.mem_dat    = md;
        #1;
        check("req_ready", 32'(bus.req_ready), 32'(!rst && !m_pend));
        cnt_n = m_cnt + 16'(m_en);
        if (rst) begin
            m_en = 1'b0; m_addr = '0; m_dat = '0; m_swap = 1'b0;
            m_pend = 1'b0; cnt_n = '0;
        end else if (m_pend) begin
            m_en = 1'b1; m_addr = m_pend_addr; m_dat = m_pend_dat; m_swap = 1'b1;
            arch[m_pend_addr] = m_pend_dat;
            m_pend = 1'b0;
        end else if (v && (op == WB_ALU || op == WB_LOAD)) begin
            m_en = 1'b1; m_addr = a; m_swap = 1'b0;
            m_dat = (op == WB_ALU) ? ad : md;
            arch[a] = m_dat;
        end else if (v && op == WB_SWAP) begin
            va = arch[a];
            vb = arch[b];
            m_en = 1'b1; m_addr = b; m_dat = va; m_swap = 1'b1;
            arch[b] = va;
            m_pend = 1'b1; m_pend_addr = a; m_pend_dat = vb;
        end else begin
            m_en = 1'b0; m_swap = 1'b0;
        end
        m_cnt = cnt_n;
        @(posedge clk);
        #1;
        check("rf_wr_en",   32'(bus.rf_wr_en),   32'(m_en));
        check("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(m_addr));
        check("rf_dat",     32'(bus.rf_dat),     32'(m_dat));
        check("rf_doSWAP",  32'(bus.rf_doSWAP),  32'(m_swap));
        check("wb_cnt",     32'(bus.wb_cnt),     32'(m_cnt));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, WB_NOP, '0, '0, 8'h00, 8'h00);
    endtask

    task automatic alu(input logic [PW:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, WB_ALU, a, '0, d, 8'h00);
    endtask

    task automatic check_regs();
        for (int i = 0; i < NREG; i++) begin
            check($sformatf("reg%0d", i), 32'(rf_mem[i]), 32'(arch[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] cnt0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = WB_NOP;
        bus.req_addr_a = '0;
        bus.req_addr_b = '0;
        bus.alu_dat    = '0;
        bus.mem_dat    = '0;

        // Reset two cycles, then a single ALU write.
        step(1'b1, 1'b0, WB_NOP, '0, '0, 8'h00, 8'h00);
        step(1'b1, 1'b0, WB_NOP, '0, '0, 8'h00, 8'h00);
        alu(5'd3, 8'h5A);
        idle();
        check("alu_r3", 32'(rf_mem[3]), 32'h5A);
        check("alu_cnt", 32'(bus.wb_cnt), 32'd1);

        // Give every register a defined value.
        for (int i = 0; i < NREG; i++) alu(5'(i), 8'($urandom));
        idle();
        check_regs();

        // Plain swap.
        alu(5'd1, 8'h11);
        alu(5'd2, 8'h22);
        step(1'b0, 1'b1, WB_SWAP, 5'd1, 5'd2, 8'h00, 8'h00);
        check("swap_w1_addr", 32'(bus.rf_wr_addr), 32'd2);
        check("swap_w1_dat",  32'(bus.rf_dat),     32'h11);
        step(1'b0, 1'b1, WB_ALU, 5'd7, '0, 8'hEE, 8'h00);
        check("swap_w2_addr", 32'(bus.rf_wr_addr), 32'd1);
        check("swap_w2_dat",  32'(bus.rf_dat),     32'h22);
        idle();
        check("swap_r1", 32'(rf_mem[1]), 32'h22);
        check("swap_r2", 32'(rf_mem[2]), 32'h11);

        // Load immediately followed by a swap reading the loaded register.
        alu(5'd5, 8'h09);
        step(1'b0, 1'b1, WB_LOAD, 5'd4, '0, 8'h00, 8'h77);
        step(1'b0, 1'b1, WB_SWAP, 5'd4, 5'd5, 8'h00, 8'h00);
        idle();
        idle();
        check("fwd_r5", 32'(rf_mem[5]), 32'h77);
        check("fwd_r4", 32'(rf_mem[4]), 32'h09);

        // Self-swap, then a NOP.
        alu(5'd6, 8'hC3);
        idle();
        cnt0 = m_cnt;
        step(1'b0, 1'b1, WB_SWAP, 5'd6, 5'd6, 8'h00, 8'h00);
        idle();
        idle();
        check("self_r6", 32'(rf_mem[6]), 32'hC3);
        check("self_cnt", 32'(bus.wb_cnt), 32'(cnt0 + 16'd2));
        step(1'b0, 1'b1, WB_NOP, 5'd6, 5'd6, 8'h55, 8'h55);
        check("nop_en", 32'(bus.rf_wr_en), 32'd0);
        idle();
        check("nop_cnt", 32'(bus.wb_cnt), 32'(cnt0 + 16'd2));

        // Reset while in SWAP1: only the addr_b write lands.
        alu(5'd8, 8'hA1);
        alu(5'd9, 8'hB2);
        step(1'b0, 1'b1, WB_SWAP, 5'd8, 5'd9, 8'h00, 8'h00);
        step(1'b1, 1'b1, WB_ALU, 5'd10, '0, 8'h3C, 8'h00);
        idle();
        check("rst_r9", 32'(rf_mem[9]), 32'hA1);
        check("rst_r8", 32'(rf_mem[8]), 32'hA1);
        check_regs();

        // Randomised traffic on a small address window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 wb_op_t'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        idle();
        idle();
        check_regs();

        // Counter wrap after 65536 writes from reset.
        step(1'b1, 1'b0, WB_NOP, '0, '0, 8'h00, 8'h00);
        for (int i = 0; i < 65535; i++) alu(5'(i), 8'(i));
        idle();
        check("cnt_ffff", 32'(bus.wb_cnt), 32'hFFFF);
        alu(5'd0, 8'h42);
        idle();
        check("cnt_wrap", 32'(bus.wb_cnt), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back sequencer directly upstream of the register file write port. It accepts one write-back request per cycle: ALU result, load data, NOP, or a two-register SWAP. It drives the register file's single write port with registered signals. SWAP runs as a two-write sequence from captured operands, with forwarding from the in-flight write so that back-to-back requests see correct data.

## Interface
Parameters:
- PW, 4, register pointer parameter; all address ports are PW+1 bits wide to match the register file ports.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  request accepted at next posedge when req_valid && req_ready.
- req_op  in  2  wb_op_t: 0 WB_NOP, 1 WB_ALU, 2 WB_LOAD, 3 WB_SWAP.
- req_addr_a  in  PW+1  destination for ALU/LOAD; first swap register.
- req_addr_b  in  PW+1  second swap register; ignored otherwise.
- alu_dat  in  8  ALU result, used by WB_ALU.
- mem_dat  in  8  load data, used by WB_LOAD.
- rf_datA  in  8  register file read port A, reading req_addr_a; valid combinationally.
- rf_datB  in  8  register file read port B, reading req_addr_b; valid combinationally.
- rf_wr_en  out  1  register file write enable (registered).
- rf_wr_addr  out  PW+1  register file write address (registered).
- rf_dat  out  8  register file write data (registered).
- rf_doSWAP  out  1  high during both swap write cycles (registered).
- wb_cnt  out  16  count of issued register writes, wraps.

## Operation
- States: IDLE, WRITE, SWAP1, SWAP2.
- req_ready = !reset && state != SWAP1.
- Accepted WB_ALU/WB_LOAD:
  - next state WRITE.
  - rf_wr_en=1, rf_wr_addr=req_addr_a, rf_dat=alu_dat or mem_dat.
- Accepted WB_NOP, or no acceptance from IDLE/WRITE/SWAP2:
  - next state IDLE, rf_wr_en=0.
  - rf_wr_addr and rf_dat hold their previous values.
- Accepted WB_SWAP:
  - Capture hold_a = fwd(req_addr_a, rf_datA) and hold_b = fwd(req_addr_b, rf_datB), plus both addresses.
  - Next state SWAP1; drives rf_wr_en=1, rf_wr_addr=addr_b, rf_dat=hold_a, rf_doSWAP=1.
- SWAP1: unconditionally next state SWAP2; drives rf_wr_en=1, rf_wr_addr=addr_a, rf_dat=hold_b, rf_doSWAP=1.
- SWAP2 behaves like IDLE/WRITE for new requests; rf_doSWAP=0 unless the new request is a swap.
- Forwarding, fwd(addr, rd):
  - If rf_wr_en==1 and rf_wr_addr==addr at the capture edge, return rf_dat; otherwise return rd.
  - Covers a swap accepted in WRITE or SWAP2, where the register file has not yet committed the pending write.
- Swap with addr_a==addr_b: both writes are issued with the same value and the register is unchanged. It still takes two cycles.
- wb_cnt increments by 1 on every posedge where rf_wr_en==1; 0xFFFF wraps to 0x0000.

## Timing
- Reset values: state IDLE, rf_wr_en=0, rf_wr_addr=0, rf_dat=0, rf_doSWAP=0, wb_cnt=0. req_ready=0 while reset is high.
- ALU/LOAD latency: accepted at edge N, write presented in cycle N..N+1, register updated at edge N+1. A read of that register is valid from cycle N+1.
- SWAP: accepted at edge N; addr_b written at edge N+1, addr_a written at edge N+2. req_ready is low for one cycle (SWAP1). Throughput is one swap per two cycles.
- Back-to-back ALU writes: one per cycle, no bubbles.
- Reset while in SWAP1 or SWAP2: the next edge gives IDLE with rf_wr_en=0. A pending second swap write is dropped; a first write already committed stays.
- req_valid held with req_ready low: no acceptance, and request inputs may change freely.

## Structure
- Package wb_pkg:
  - typedef enum logic[1:0] wb_op_t {WB_NOP, WB_ALU, WB_LOAD, WB_SWAP}.
  - typedef enum logic[1:0] wb_state_t {IDLE, WRITE, SWAP1, SWAP2}.
  - localparam WB_CNT_W=16.
- One sub-module: wb_fwd_mux, the combinational forwarding compare/mux, instantiated twice (A and B capture).
- Integration: rf_* outputs connect to the register file's wr_en/wr_addr/dat_in/doSWAP ports. The register file's datA_out and datB_out feed rf_datA and rf_datB.

## Test plan
- Reset then ALU write: reset 2 cycles, then WB_ALU addr_a=3, alu_dat=0x5A. Response: rf_wr_en=1, rf_wr_addr=3, rf_dat=0x5A one cycle; register 3 reads 0x5A after; wb_cnt=1.
- Swap: r1=0x11, r2=0x22, WB_SWAP a=1,b=2. Response: cycle 1 writes r2<-0x11, cycle 2 writes r1<-0x22; req_ready low for exactly one cycle; rf_doSWAP high for two cycles.
- Forwarding hazard: WB_LOAD r4<-0x77, immediately followed by WB_SWAP a=4,b=5 with r5=0x09. Response: r5=0x77, r4=0x09, not the stale r4 value.
- Self-swap and NOP: WB_SWAP a=b=6 (r6=0xC3) gives two writes of 0xC3, r6 unchanged, wb_cnt+2. WB_NOP gives rf_wr_en=0 and wb_cnt unchanged.
- Reset mid-swap: assert reset in SWAP1. Response: addr_b write committed, addr_a unchanged; outputs at reset values the next cycle.
- Counter wrap: preload via 65535 ALU writes, then one more. Response: wb_cnt=0x0000.
